npc_predictor: RTL and testbench

Next-PC generator for the pipelined MIPS core. It replaces the combinational next-PC mux with a fetch-stage PC register and a parametrised direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. It predicts the next fetch address every cycle and accepts resolved control-flow outcomes from the execute stage. On a misprediction it raises a flush and redirects fetch. There is no architectural delay slot in this generation; the pipeline kills all younger instructions on `flush`.

---
 rtl/npc_predictor_if.sv | 30 +++
 rtl/npc_predictor.sv | 160 ++++++++++++++++
 tb/tb_npc_predictor.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/npc_predictor_if.sv
// rtl/npc_predictor_if.sv - fetch/resolve bundle between the pipeline and the next-PC predictor
interface npc_predictor_if;
   logic        stall;
   logic [31:0] pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        res_valid;
   logic [1:0]  res_kind;
   logic [31:0] res_pc;
   logic        res_taken;
   logic [31:0] res_target;
   logic        res_pred_taken;
   logic [31:0] res_pred_target;
   logic        flush;
   logic [15:0] mispredict_cnt;

   // pipeline side: drives stall and the execute-stage resolution
   modport master (
      output stall, res_valid, res_kind, res_pc, res_taken, res_target,
             res_pred_taken, res_pred_target,
      input  pc, pred_taken, pred_target, flush, mispredict_cnt
   );

   // predictor side
   modport slave (
      input  stall, res_valid, res_kind, res_pc, res_taken, res_target,
             res_pred_taken, res_pred_target,
      output pc, pred_taken, pred_target, flush, mispredict_cnt
   );
endinterface

// File: rtl/npc_predictor.sv
// rtl/npc_predictor.sv - fetch PC register with direct-mapped BTB and 2-bit direction counters
module npc_predictor #(
   parameter int          ENTRIES  = 16,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input logic            clk,
   input logic            reset,
   npc_predictor_if.slave bus
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = 30 - IDX_W;

   logic             btb_valid  [ENTRIES];
   logic [TAG_W-1:0] btb_tag    [ENTRIES];
   logic [31:0]      btb_target [ENTRIES];
   logic [1:0]       btb_ctr    [ENTRIES];

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [15:0] cnt_q;

   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_hit;
   logic             pred_taken;
   logic [31:0]      pred_target;

   logic             actual_taken;
   logic [31:0]      correct;
   logic             flush;

   logic [IDX_W-1:0] up_idx;
   logic [TAG_W-1:0] up_tag;
   logic             up_hit;
   logic             up_we;
   logic             up_clr;
   logic [31:0]      up_target;
   logic [1:0]       up_ctr;

   assign bus.pc             = pc_q;
   assign bus.pred_taken     = pred_taken;
   assign bus.pred_target    = pred_target;
   assign bus.flush          = flush;
   assign bus.mispredict_cnt = cnt_q;

   // Fetch-side lookup: predict taken only on a tag hit with a strong-enough counter
   always_comb begin
      lk_idx      = pc_q[IDX_W+1:2];
      lk_tag      = pc_q[31:IDX_W+2];
      lk_hit      = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);
      pred_taken  = 1'b0;
      pred_target = pc_q + 32'd4;
      if (lk_hit && btb_ctr[lk_idx][1]) begin
         pred_taken  = 1'b1;
         pred_target = btb_target[lk_idx];
      end
   end

   // Execute-side resolution: true direction, correct fetch address and mispredict detect
   always_comb begin
      case (bus.res_kind)
         2'b01:   actual_taken = bus.res_taken;
         2'b10,
         2'b11:   actual_taken = 1'b1;
         default: actual_taken = 1'b0;
      endcase
      correct = actual_taken ? bus.res_target : (bus.res_pc + 32'd4);
      flush   = bus.res_valid &&
                ((bus.res_pred_taken != actual_taken) ||
                 (actual_taken && (bus.res_pred_target != bus.res_target)));
   end

   // BTB update decision for the resolved instruction's slot
   always_comb begin
      up_idx    = bus.res_pc[IDX_W+1:2];
      up_tag    = bus.res_pc[31:IDX_W+2];
      up_hit    = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);
      up_we     = 1'b0;
      up_clr    = 1'b0;
      up_target = btb_target[up_idx];
      up_ctr    = btb_ctr[up_idx];
      if (bus.res_valid) begin
         case (bus.res_kind)
            2'b01: begin
               if (up_hit) begin
                  up_we = 1'b1;
                  if (bus.res_taken) begin
                     up_ctr    = (btb_ctr[up_idx] == 2'b11) ? 2'b11 : btb_ctr[up_idx] + 2'd1;
                     up_target = bus.res_target;
                  end else begin
                     up_ctr    = (btb_ctr[up_idx] == 2'b00) ? 2'b00 : btb_ctr[up_idx] - 2'd1;
                  end
               end else if (bus.res_taken) begin
                  // first taken sighting allocates weakly taken
                  up_we     = 1'b1;
                  up_target = bus.res_target;
                  up_ctr    = 2'b10;
               end
            end
            2'b10,
            2'b11: begin
               up_we     = 1'b1;
               up_target = bus.res_target;
               up_ctr    = 2'b11;
            end
            default: begin
               // a non-control instruction hitting means the entry is stale or aliased
               up_clr = up_hit;
            end
         endcase
      end
   end

   // BTB storage; writes land at the clock edge so same-cycle lookups see old contents
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= '0;
            btb_ctr[i]    <= 2'b01;
         end
      end else if (up_we) begin
         btb_valid[up_idx]  <= 1'b1;
         btb_tag[up_idx]    <= up_tag;
         btb_target[up_idx] <= up_target;
         btb_ctr[up_idx]    <= up_ctr;
      end else if (up_clr) begin
         btb_valid[up_idx]  <= 1'b0;
      end
   end

   // Next fetch address: a redirect beats a stall, otherwise follow the prediction
   always_comb begin
      pc_d = pred_target;
      if (flush) begin
         pc_d = correct;
      end else if (bus.stall) begin
         pc_d = pc_q;
      end
   end

   // Fetch PC register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // Mispredict counter, free-running wrap
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= 16'd0;
      end else if (flush) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end
endmodule

// File: tb/tb_npc_predictor.sv
// tb/tb_npc_predictor.sv - directed and randomized checks of npc_predictor against a reference model
module tb_npc_predictor;
   localparam int          ENTRIES  = 16;
   localparam int          IDX_W    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   logic clk = 1'b0;
   logic reset = 1'b1;

   npc_predictor_if bus ();

   npc_predictor #(.ENTRIES(ENTRIES), .RESET_PC(RESET_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] tag;
      logic [31:0] tgt;
      int          ctr;
   } ent_t;

   ent_t        mbtb [int];
   logic [31:0] m_pc;
   logic [15:0] m_cnt;
   int          total = 0;
   int          bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int key_of(input logic [31:0] a);
      return int'((a >> 2) % ENTRIES);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a);
      return a >> (2 + IDX_W);
   endfunction

   task automatic model_pred(input logic [31:0] a, output logic t, output logic [31:0] tg);
      int k;
      k  = key_of(a);
      t  = 1'b0;
      tg = a + 32'd4;
      if (mbtb.exists(k) && mbtb[k].tag == tag_of(a) && mbtb[k].ctr >= 2) begin
         t  = 1'b1;
         tg = mbtb[k].tgt;
      end
   endtask

   task automatic model_reset();
      mbtb.delete();
      m_pc  = RESET_PC;
      m_cnt = 16'd0;
   endtask

   // One clock: drive, check combinational outputs against the model, clock, advance the model
   task automatic cycle(input logic st, input logic rv, input logic [1:0] rk,
                        input logic [31:0] rpc, input logic rt, input logic [31:0] rtgt,
                        input logic rpt, input logic [31:0] rptgt);
      logic        ep_t, at, ef, hit;
      logic [31:0] ep_tgt, corr;
      int          k;
      bus.stall = st; bus.res_valid = rv; bus.res_kind = rk; bus.res_pc = rpc;
      bus.res_taken = rt; bus.res_target = rtgt;
      bus.res_pred_taken = rpt; bus.res_pred_target = rptgt;
      #1;
      model_pred(m_pc, ep_t, ep_tgt);
      at   = (rk == 2'b01) ? rt : (rk != 2'b00);
      corr = at ? rtgt : rpc + 32'd4;
      ef   = rv && ((rpt != at) || (at && rptgt != rtgt));
      chk("pc", bus.pc, m_pc);
      chk("pred_taken", bus.pred_taken, ep_t);
      chk("pred_target", bus.pred_target, ep_tgt);
      chk("flush", bus.flush, ef);
      chk("mispredict_cnt", bus.mispredict_cnt, m_cnt);
      @(posedge clk);
      #1;
      if (rv) begin
         k   = key_of(rpc);
         hit = mbtb.exists(k) && mbtb[k].tag == tag_of(rpc);
         if (rk == 2'b01) begin
            if (hit) begin
               if (rt) begin
                  mbtb[k].ctr = (mbtb[k].ctr < 3) ? mbtb[k].ctr + 1 : 3;
                  mbtb[k].tgt = rtgt;
               end else begin
                  mbtb[k].ctr = (mbtb[k].ctr > 0) ? mbtb[k].ctr - 1 : 0;
               end
            end else if (rt) begin
               mbtb[k] = '{tag: tag_of(rpc), tgt: rtgt, ctr: 2};
            end
         end else if (rk != 2'b00) begin
            mbtb[k] = '{tag: tag_of(rpc), tgt: rtgt, ctr: 3};
         end else if (hit) begin
            mbtb.delete(k);
         end
      end
      if (ef) begin
         m_pc  = corr;
         m_cnt = m_cnt + 16'd1;
      end else if (!st) begin
         m_pc = ep_tgt;
      end
   endtask

   task automatic idle(input logic st);
      cycle(st, 1'b0, 2'b00, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Redirect fetch with a mispredicted jump resolved at an unrelated address
   task automatic jmp(input logic [31:0] tgt);
      cycle(1'b0, 1'b1, 2'b10, 32'h0000_3044, 1'b1, tgt, 1'b0, 32'h0);
   endtask

   initial begin
      logic [31:0] rpc, rtgt, rptgt;
      logic [1:0]  rk;
      logic        rt, rpt, pt;

      bus.stall = 1'b0; bus.res_valid = 1'b0; bus.res_kind = 2'b00; bus.res_pc = '0;
      bus.res_taken = 1'b0; bus.res_target = '0;
      bus.res_pred_taken = 1'b0; bus.res_pred_target = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // reset state, free run, stall
      chk("rst_pc", bus.pc, 32'h3000);
      chk("rst_pred_taken", bus.pred_taken, 1'b0);
      chk("rst_pred_target", bus.pred_target, 32'h3004);
      chk("rst_cnt", bus.mispredict_cnt, 16'd0);
      repeat (3) idle(1'b0);
      chk("run_pc", bus.pc, 32'h300C);
      repeat (2) idle(1'b1);
      chk("stall_pc", bus.pc, 32'h300C);

      // taken branch allocates, later predicted
      cycle(1'b0, 1'b1, 2'b01, 32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0);
      chk("alloc_pc", bus.pc, 32'h3040);
      chk("alloc_cnt", bus.mispredict_cnt, 16'd1);
      jmp(32'h3010);
      chk("hit_pred_taken", bus.pred_taken, 1'b1);
      chk("hit_pred_target", bus.pred_target, 32'h3040);

      // same branch not taken: counter falls to 01
      cycle(1'b0, 1'b1, 2'b01, 32'h3010, 1'b0, 32'h0, 1'b1, 32'h3040);
      chk("nt_pc", bus.pc, 32'h3014);
      jmp(32'h3010);
      chk("weak_pred_taken", bus.pred_taken, 1'b0);

      // alias at index 4 and invalidation by a non-control resolve
      cycle(1'b0, 1'b1, 2'b01, 32'h3010, 1'b1, 32'h3040, 1'b0, 32'h0);
      jmp(32'h3050);
      chk("alias_pred_taken", bus.pred_taken, 1'b0);
      cycle(1'b0, 1'b1, 2'b00, 32'h3010, 1'b0, 32'h0, 1'b1, 32'h3040);
      chk("inval_pc", bus.pc, 32'h3014);
      jmp(32'h3010);
      chk("inval_pred_taken", bus.pred_taken, 1'b0);

      // jr with wrong target
      cycle(1'b0, 1'b1, 2'b11, 32'h3020, 1'b1, 32'h3200, 1'b1, 32'h3100);
      chk("jr_pc", bus.pc, 32'h3200);
      jmp(32'h3020);
      chk("jr_pred_target", bus.pred_target, 32'h3200);

      // flush beats stall
      cycle(1'b1, 1'b1, 2'b10, 32'h3044, 1'b1, 32'h3400, 1'b0, 32'h0);
      chk("flush_stall_pc", bus.pc, 32'h3400);

      // 32-bit wrap
      jmp(32'hFFFF_FFFC);
      chk("wrap_pred_target", bus.pred_target, 32'h0);
      idle(1'b0);
      chk("wrap_pc", bus.pc, 32'h0);

      // res_valid low: no flush whatever the rest says
      cycle(1'b0, 1'b0, 2'b01, 32'h3010, 1'b1, 32'h3ABC, 1'b0, 32'h0);
      chk("novalid_flush", bus.flush, 1'b0);

      // reset during a redirect
      bus.res_valid = 1'b1; bus.res_kind = 2'b10; bus.res_pc = 32'h3080;
      bus.res_taken = 1'b1; bus.res_target = 32'h3500; bus.res_pred_taken = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_pc", bus.pc, RESET_PC);
      chk("rst_mid_cnt", bus.mispredict_cnt, 16'd0);
      reset = 1'b0;
      model_reset();
      idle(1'b0);
      jmp(32'h3020);
      chk("rst_mid_btb", bus.pred_taken, 1'b0);

      // randomized traffic over a small address pool to force hits and aliases
      for (int n = 0; n < 400; n++) begin
         rpc  = 32'h3000 + 32'(4 * $urandom_range(0, 31));
         rtgt = 32'h3000 + 32'(4 * $urandom_range(0, 31));
         rk   = 2'($urandom_range(0, 3));
         rt   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            model_pred(rpc, pt, rptgt);
            rpt = pt;
         end else begin
            rpt   = 1'($urandom_range(0, 1));
            rptgt = ($urandom_range(0, 1) == 1) ? rtgt : 32'h3000 + 32'(4 * $urandom_range(0, 31));
         end
         cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) != 0), rk, rpc, rt, rtgt, rpt, rptgt);
      end
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
